// File: rtl/fifo_tx_pkg.sv
// rtl/fifo_tx_pkg.sv - shared state encoding and defaults for the FIFO serial transmitter
package fifo_tx_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_BAUD_DIV = 4;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period down-counter; tick marks the last clk of each bit
module baud_tick #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Held at TOP while cleared so the first bit of a frame gets a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == '0) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops words from the FIFO and sends them as async serial frames
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BAUD_DIV  = DEF_BAUD_DIV,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         next_state;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic [BW-1:0]     bit_cnt;
  logic              baud_clear;
  logic              tick;

  baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // All outputs decode from state and registers only, never directly from inputs.
  always_comb begin
    next_state = state;
    tx         = IDLE_LEVEL;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    baud_clear = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        baud_clear = 1'b1;
        if (enable && !fifo_empty) next_state = FETCH;
      end
      FETCH: begin
        fifo_rd_en = 1'b1;
        baud_clear = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        baud_clear = 1'b1;
        next_state = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) next_state = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (tick && bit_cnt == LAST_BIT) next_state = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        tx = parity;
        if (tick) next_state = STOP;
      end
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        baud_clear = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg  <= fifo_data;
          parity <= ^fifo_data;
        end
        START: bit_cnt <= '0;
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - scoreboard bench for fifo_serial_tx (default and no-parity/div-2 instances)
module tb_fifo_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic en_a = 1'b1, en_b = 1'b1;
  logic empty_a = 1'b1, empty_b = 1'b1;
  logic [3:0] data_a = '0, data_b = '0;
  logic rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [3:0] fq_a[$], fq_b[$], ex_a[$], ex_b[$];
  int rdcnt_a = 0, rdtot_a = 0, rdcnt_b = 0, idle_run = 0;
  int n_a = 0, n_b = 0;
  bit in_a = 0, in_b = 0, gap_chk = 0, gap_armed = 0;
  logic [63:0] wave_a = '0, wave_b = '0;

  fifo_serial_tx u_dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .fifo_empty(empty_a), .fifo_data(data_a),
    .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_serial_tx #(.DATA_W(4), .BAUD_DIV(2), .PARITY_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .fifo_empty(empty_b), .fifo_data(data_b),
    .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int exp_len(input int div, input bit par);
    return (6 + int'(par)) * div;
  endfunction

  // Expected line level per clk sample: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [63:0] exp_wave(input logic [3:0] w, input int div, input bit par);
    logic [63:0] r;
    int b;
    r = '0;
    for (int i = 0; i < exp_len(div, par); i++) begin
      b = i / div;
      if (b == 0) r[i] = 1'b0;
      else if (b <= 4) r[i] = w[b-1];
      else if (par && b == 5) r[i] = ^w;
      else r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic push_a(input logic [3:0] w);
    fq_a.push_back(w);
    ex_a.push_back(w);
    empty_a = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] w);
    fq_b.push_back(w);
    ex_b.push_back(w);
    empty_b = 1'b0;
  endtask

  // FIFO models: registered read data, flags update after the read edge.
  always @(posedge clk) begin
    if (rd_a) begin
      check("rd_nonempty_a", 64'(fq_a.size() != 0), 64'd1);
      if (fq_a.size() != 0) begin
        data_a  <= fq_a.pop_front();
        empty_a <= (fq_a.size() == 0);
      end else data_a <= '0;
    end
    if (rd_b) begin
      check("rd_nonempty_b", 64'(fq_b.size() != 0), 64'd1);
      if (fq_b.size() != 0) begin
        data_b  <= fq_b.pop_front();
        empty_b <= (fq_b.size() == 0);
      end else data_b <= '0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] w;
    if (rst) begin
      in_a = 0; rdcnt_a = 0; n_a = 0;
    end else begin
      if (rd_a) begin rdcnt_a++; rdtot_a++; end
      if (!in_a && !tx_a) begin
        if (gap_armed) check("gap_a", 64'(idle_run), 64'd3);
        gap_armed = 0;
        in_a = 1; n_a = 0; wave_a = '0;
      end else if (!in_a) idle_run++;
      if (in_a) begin
        if (n_a < 64) wave_a[n_a] = tx_a;
        n_a++;
      end
      if (done_a) begin
        if (ex_a.size() == 0) check("done_unexpected_a", 64'(ex_a.size()), 64'd1);
        else begin
          w = ex_a.pop_front();
          check("frame_len_a", 64'(n_a), 64'(exp_len(4, 1)));
          check("wave_a", wave_a, exp_wave(w, 4, 1));
          check("rd_per_frame_a", 64'(rdcnt_a), 64'd1);
        end
        in_a = 0; rdcnt_a = 0; idle_run = 0; gap_armed = gap_chk;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] w;
    if (rst) begin
      in_b = 0; rdcnt_b = 0; n_b = 0;
    end else begin
      if (rd_b) rdcnt_b++;
      if (!in_b && !tx_b) begin
        in_b = 1; n_b = 0; wave_b = '0;
      end
      if (in_b) begin
        if (n_b < 64) wave_b[n_b] = tx_b;
        n_b++;
      end
      if (done_b) begin
        if (ex_b.size() == 0) check("done_unexpected_b", 64'(ex_b.size()), 64'd1);
        else begin
          w = ex_b.pop_front();
          check("frame_len_b", 64'(n_b), 64'(exp_len(2, 0)));
          check("wave_b", wave_b, exp_wave(w, 2, 0));
          check("rd_per_frame_b", 64'(rdcnt_b), 64'd1);
        end
        in_b = 0; rdcnt_b = 0;
      end
    end
  end

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && (ex_a.size() != 0 || ex_b.size() != 0); i++) @(posedge clk);
    #1;
    check(name, 64'(ex_a.size() + ex_b.size()), 64'd0);
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40 && tx_a; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(tx_a), 64'd0);
  endtask

  initial begin
    int rd_snap;
    bit got;
    #1;
    check("rst_tx_a", 64'(tx_a), 64'd1);
    check("rst_rd_a", 64'(rd_a), 64'd0);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_tx_b", 64'(tx_b), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    check("idle_rd_cnt", 64'(rdtot_a), 64'd0);
    check("idle_busy", 64'(busy_a), 64'd0);
    check("idle_tx", 64'(tx_a), 64'd1);

    // Single word 4'hA: FETCH, LOAD, then start bit on the third edge.
    push_a(4'hA);
    @(posedge clk); #1;
    check("lat_fetch_rd", 64'(rd_a), 64'd1);
    check("lat_fetch_busy", 64'(busy_a), 64'd1);
    @(posedge clk); #1;
    check("lat_load_rd", 64'(rd_a), 64'd0);
    check("lat_load_tx", 64'(tx_a), 64'd1);
    @(posedge clk); #1;
    check("lat_start_tx", 64'(tx_a), 64'd0);
    drain("drain_hA", 100);

    push_b(4'h7);
    drain("drain_h7", 100);

    // Eight back-to-back words: 3-cycle high gap between frames.
    gap_chk = 1; gap_armed = 0;
    rd_snap = rdtot_a;
    for (int i = 1; i <= 8; i++) push_a(4'(i));
    drain("drain_burst", 400);
    repeat (5) @(posedge clk);
    #1;
    check("burst_rd_cnt", 64'(rdtot_a - rd_snap), 64'd8);
    check("burst_empty", 64'(empty_a), 64'd1);
    gap_chk = 0; gap_armed = 0;

    // Enable dropped mid-DATA: frame finishes, no further pop until re-enabled.
    push_a(4'h3);
    push_a(4'h5);
    wait_start("start_h3");
    repeat (9) @(posedge clk);
    #1 en_a = 1'b0;
    for (int i = 0; i < 60 && ex_a.size() > 1; i++) @(posedge clk);
    rd_snap = rdtot_a;
    repeat (30) @(posedge clk);
    #1;
    check("dis_left", 64'(ex_a.size()), 64'd1);
    check("dis_no_rd", 64'(rdtot_a - rd_snap), 64'd0);
    check("dis_busy", 64'(busy_a), 64'd0);
    en_a = 1'b1;
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk); #1;
      if (rd_a) got = 1;
    end
    check("resume_rd", 64'(got), 64'd1);
    drain("drain_h5", 100);

    // Reset during PARITY of 4'h9: line goes high at once, 4'h6 follows cleanly.
    push_a(4'h9);
    push_a(4'h6);
    wait_start("start_h9");
    repeat (22) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_tx", 64'(tx_a), 64'd1);
    check("arst_busy", 64'(busy_a), 64'd0);
    void'(ex_a.pop_front());
    @(posedge clk);
    #1 rst = 1'b0;
    drain("drain_h6", 100);
    check("final_fifo_empty", 64'(fq_a.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
